// File: rtl/flit_replay_pkg.sv
// Shared types for the FLIT replay path (also used by replay_nak_control).
package flit_replay_pkg;

  localparam int unsigned REPLAY_TYPE_W = 2;

  typedef enum logic [REPLAY_TYPE_W-1:0] {
    STANDARD_REPLAY  = 2'b01,
    SELECTIVE_REPLAY = 2'b10
  } replay_type_t;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StFetch,
    StWait,
    StSend,
    StDone
  } replay_state_t;

endpackage

// File: rtl/flit_replay_engine_if.sv
// Retry-buffer read port and replay FLIT stream toward the TX arbiter.
// master = replay engine side, slave = buffer/arbiter side.
interface flit_replay_engine_if #(
  parameter int unsigned SEQ_W  = 16,
  parameter int unsigned FLIT_W = 256
);

  logic              rb_rd_en;
  logic [SEQ_W-1:0]  rb_rd_seq;
  logic [FLIT_W-1:0] rb_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [FLIT_W-1:0] out_data;
  logic [SEQ_W-1:0]  out_seq;

  modport master (
    output rb_rd_en, rb_rd_seq, out_valid, out_data, out_seq,
    input  rb_rd_data, out_ready
  );

  modport slave (
    input  rb_rd_en, rb_rd_seq, out_valid, out_data, out_seq,
    output rb_rd_data, out_ready
  );

endinterface

// File: rtl/flit_replay_engine.sv
// Replays FLITs from the TX retry buffer after a scheduled replay, one FLIT
// per FETCH/WAIT/SEND round, and tracks consecutive replays for retrain.
module flit_replay_engine
  import flit_replay_pkg::*;
#(
  parameter int unsigned SEQ_W        = 16,
  parameter int unsigned FLIT_W       = 256,
  parameter int unsigned RB_DEPTH     = 512,
  parameter int unsigned REPLAY_NUM_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     replay_scheduled,
  input  logic [REPLAY_TYPE_W-1:0] replay_type,
  input  logic [SEQ_W-1:0]         replay_start_seq,
  input  logic [SEQ_W-1:0]         next_tx_seq,
  input  logic                     ack_advance,
  input  logic                     link_down,
  flit_replay_engine_if.master     bus,
  output logic                     replay_in_progress,
  output logic                     replay_accept,
  output logic                     replay_done,
  output logic                     replay_range_err,
  output logic                     retrain_req
);

  localparam logic [SEQ_W-1:0]        SeqOne     = SEQ_W'(1);
  localparam logic [REPLAY_NUM_W-1:0] NumOne     = REPLAY_NUM_W'(1);
  localparam logic [SEQ_W:0]          RbDepthExt = (SEQ_W + 1)'(RB_DEPTH);

  replay_state_t             state_q, state_d;
  replay_type_t              type_q, type_d;
  logic [SEQ_W-1:0]          seq_q, seq_d;
  logic [SEQ_W-1:0]          span_q, span_d;
  logic [SEQ_W-1:0]          remain_q, remain_d;
  logic [FLIT_W-1:0]         hold_data_q, hold_data_d;
  logic [SEQ_W-1:0]          hold_seq_q, hold_seq_d;
  logic                      accept_q, accept_d;
  logic                      retrain_q, retrain_d;
  logic [REPLAY_NUM_W-1:0]   replay_num_q, replay_num_d;

  logic rd_en;
  logic send_valid;
  logic done_pulse;
  logic range_err_pulse;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      type_q       <= STANDARD_REPLAY;
      seq_q        <= '0;
      span_q       <= '0;
      remain_q     <= '0;
      hold_data_q  <= '0;
      hold_seq_q   <= '0;
      accept_q     <= 1'b0;
      retrain_q    <= 1'b0;
      replay_num_q <= '0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      seq_q        <= seq_d;
      span_q       <= span_d;
      remain_q     <= remain_d;
      hold_data_q  <= hold_data_d;
      hold_seq_q   <= hold_seq_d;
      accept_q     <= accept_d;
      retrain_q    <= retrain_d;
      replay_num_q <= replay_num_d;
    end
  end

  // Next-state, datapath updates and state-decoded strobes.
  always_comb begin
    state_d         = state_q;
    type_d          = type_q;
    seq_d           = seq_q;
    span_d          = span_q;
    remain_d        = remain_q;
    hold_data_d     = hold_data_q;
    hold_seq_d      = hold_seq_q;
    accept_d        = 1'b0;
    retrain_d       = 1'b0;
    replay_num_d    = replay_num_q;
    rd_en           = 1'b0;
    send_valid      = 1'b0;
    done_pulse      = 1'b0;
    range_err_pulse = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (replay_scheduled && !link_down) begin
          seq_d    = replay_start_seq;
          span_d   = next_tx_seq - replay_start_seq;
          // Unknown encodings fall back to a standard (go-back-N) replay.
          type_d   = (replay_type == SELECTIVE_REPLAY) ? SELECTIVE_REPLAY : STANDARD_REPLAY;
          accept_d = 1'b1;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (span_q == '0) begin
          state_d = StDone;
        end else if ({1'b0, span_q} > RbDepthExt) begin
          range_err_pulse = 1'b1;
          state_d         = StIdle;
        end else begin
          remain_d = (type_q == SELECTIVE_REPLAY) ? SeqOne : span_q;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        rd_en   = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        hold_data_d = bus.rb_rd_data;
        hold_seq_d  = seq_q;
        state_d     = StSend;
      end
      StSend: begin
        send_valid = 1'b1;
        if (bus.out_ready) begin
          remain_d = remain_q - SeqOne;
          seq_d    = seq_q + SeqOne;
          state_d  = (remain_q == SeqOne) ? StDone : StFetch;
        end
      end
      StDone: begin
        done_pulse = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything; any read in flight is simply never captured.
    if (link_down && (state_q != StIdle)) begin
      state_d         = StIdle;
      rd_en           = 1'b0;
      done_pulse      = 1'b0;
      range_err_pulse = 1'b0;
    end

    // Consecutive-replay counter: ack clears and beats a simultaneous accept.
    if (ack_advance) begin
      replay_num_d = '0;
    end else if (accept_d) begin
      replay_num_d = replay_num_q + NumOne;
      retrain_d    = &replay_num_q;
    end
  end

  assign bus.rb_rd_en        = rd_en;
  assign bus.rb_rd_seq       = seq_q;
  assign bus.out_valid       = send_valid;
  assign bus.out_data        = hold_data_q;
  assign bus.out_seq         = hold_seq_q;
  assign replay_in_progress  = (state_q != StIdle);
  assign replay_accept       = accept_q;
  assign retrain_req         = retrain_q;
  assign replay_done         = done_pulse;
  assign replay_range_err    = range_err_pulse;

endmodule
